// File: rtl/cbm2_pkg.sv
// Shared CBM-II bus definitions: cycle indices of the system-bus frame.
package cbm2_pkg;

    typedef enum logic [4:0] {
        CYCLE_EXT0 = 5'd0,  CYCLE_EXT1 = 5'd1,  CYCLE_EXT2 = 5'd2,  CYCLE_EXT3 = 5'd3,
        CYCLE_CPU0 = 5'd4,  CYCLE_CPU1 = 5'd5,  CYCLE_CPU2 = 5'd6,  CYCLE_CPU3 = 5'd7,
        CYCLE_COP0 = 5'd8,  CYCLE_COP1 = 5'd9,  CYCLE_COP2 = 5'd10, CYCLE_COP3 = 5'd11,
        CYCLE_VID0 = 5'd12, CYCLE_VID1 = 5'd13, CYCLE_VID2 = 5'd14, CYCLE_VID3 = 5'd15,
        CYCLE_NOP0 = 5'd16, CYCLE_NOP1 = 5'd17
    } sys_cycle_t;

    localparam logic [4:0] SLOT_CPU = 5'd4;
    localparam logic [4:0] SLOT_COP = 5'd8;
    localparam logic [4:0] SLOT_VID = 5'd12;
    localparam logic [4:0] SLOT_NOP = 5'd16;

endpackage

// File: rtl/cbm2_bus_scheduler.sv
// Time-slot scheduler for the shared CBM-II system bus: frame counter,
// phi phase, refresh/pause gating, slot flags, enables and RAM requests.
module cbm2_bus_scheduler
    import cbm2_pkg::*;
#(
    parameter int RFSH_BITS = 3,
    parameter int END_P     = 15,
    parameter int END_B     = 17
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       model,
    input  logic       turbo,
    input  logic       slow_io,
    input  logic       copro_en,
    input  logic       pause,
    input  logic       cs_ram,
    input  logic       cpu_we,
    output sys_cycle_t cycle,
    output logic       phase,
    output logic       sys_enable,
    output logic       pause_out,
    output logic       refresh,
    output logic       ext_cycle,
    output logic       cpu_cycle,
    output logic       cop_cycle,
    output logic       vid_cycle,
    output logic       en_cpu,
    output logic       en_cop,
    output logic       en_vid,
    output logic       en_io_n,
    output logic       en_io_p,
    output logic       ram_ce,
    output logic       ram_we,
    output logic       en_pixel
);

    logic [4:0]           pre_q, pre_d;
    logic                 phase_q, phase_d;
    logic [RFSH_BITS-1:0] rfsh_q, rfsh_d;
    logic                 sys_en_q, sys_en_d;
    logic                 refresh_q, refresh_d;
    logic [1:0]           pix_q, pix_d;

    logic [4:0] end_c;
    logic [4:0] cyc;
    logic       wrap, rfsh_wrap, phase_o, sys2, g;

    // >= rather than == so a Business->Professional switch at pre 16/17 still wraps
    assign end_c     = model ? 5'(END_B) : 5'(END_P);
    assign wrap      = (pre_q >= end_c);
    assign rfsh_wrap = wrap && (rfsh_q == '0);
    assign cyc       = sys_en_q ? pre_q : 5'd0;
    assign phase_o   = phase_q & sys_en_q;

    always_comb begin
        pre_d     = wrap ? 5'd0 : pre_q + 5'd1;
        rfsh_d    = wrap ? rfsh_q + RFSH_BITS'(1) : rfsh_q;
        phase_d   = sys_en_q & (phase_q ^ wrap);
        sys_en_d  = rfsh_wrap ? ~pause : sys_en_q;
        refresh_d = rfsh_wrap;
        pix_d     = (!sys_en_q || cyc == end_c) ? 2'd0 : pix_q + 2'd1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pre_q     <= '0;
            phase_q   <= 1'b0;
            rfsh_q    <= '0;
            sys_en_q  <= 1'b0;
            refresh_q <= 1'b0;
            pix_q     <= '0;
        end else begin
            pre_q     <= pre_d;
            phase_q   <= phase_d;
            rfsh_q    <= rfsh_d;
            sys_en_q  <= sys_en_d;
            refresh_q <= refresh_d;
            pix_q     <= pix_d;
        end
    end

    // CPU/COP slots run every frame at 2MHz, otherwise only in the phi2-high frame
    assign sys2 = model | (turbo & ~slow_io);
    assign g    = phase_o | sys2;

    assign cycle      = sys_cycle_t'(cyc);
    assign phase      = phase_o;
    assign sys_enable = sys_en_q;
    assign pause_out  = ~sys_en_q;
    assign refresh    = refresh_q;

    assign ext_cycle = (cyc < SLOT_CPU) && (!phase_o || rfsh_q != '0);
    assign cpu_cycle = (cyc >= SLOT_CPU) && (cyc < SLOT_COP) && g;
    assign cop_cycle = (cyc >= SLOT_COP) && (cyc < SLOT_VID) && g;
    assign vid_cycle = (cyc >= SLOT_VID) && (cyc < SLOT_NOP);

    assign en_io_n = (cyc == CYCLE_CPU2) && g;
    assign en_cpu  = (cyc == CYCLE_CPU3) && g;
    assign en_io_p = (cyc == CYCLE_COP0) && g;
    assign en_cop  = (cyc == CYCLE_COP3) && copro_en;
    assign en_vid  = (cyc == CYCLE_VID3);

    assign ram_ce = cs_ram && (((cyc == CYCLE_CPU0) && g) ||
                               ((cyc == CYCLE_COP0) && copro_en) ||
                               (cyc == CYCLE_VID0));
    assign ram_we = cpu_we && cpu_cycle;

    assign en_pixel = (pix_q == 2'd3) & ~model;

endmodule

// File: doc/cbm2_bus_scheduler.md
Name: cbm2_bus_scheduler

Overview:
- Time-slot scheduler for the shared SDRAM/system bus of the CBM-II core.
- Divides clk_sys into repeating frames of 4-clock slots: external/SDRAM-refresh (EXT), 6509 CPU (CPU), coprocessor (COP), video (VID), plus a 2-clock pad (NOP) in Business mode.
- Generates phi phase, per-slot enables and strobes, RAM CE/WE, refresh and pause gating, and the VIC pixel enable.
- Sits between the board SDRAM controller and the bus logic, CPU, VIC-II and I/O chips.

Parameters:
RFSH_BITS, 3, width of frame counter; refresh/pause sampling every 2^RFSH_BITS frames
END_P, 15, last cycle index in Professional mode (16-clock frame)
END_B, 17, last cycle index in Business mode (18-clock frame)

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high block reset
model  in  1  0=Professional, 1=Business
turbo  in  1  request 2MHz CPU (Professional only)
slow_io  in  1  current CPU access hits VIC or SID (forces 1MHz)
copro_en  in  1  coprocessor slot active
pause  in  1  pause request
cs_ram  in  1  current slot address decodes to RAM
cpu_we  in  1  CPU write
cycle  out  5  current cycle index (cbm2_pkg::sys_cycle_t)
phase  out  1  phi2 phase; toggles each frame
sys_enable  out  1  bus running
pause_out  out  1  ~sys_enable
refresh  out  1  1-clock SDRAM refresh strobe
ext_cycle, cpu_cycle, cop_cycle, vid_cycle  out  1 each  slot-active flags
en_cpu, en_cop, en_vid, en_io_n, en_io_p  out  1 each  1-clock enables
ram_ce, ram_we  out  1 each  SDRAM request/write
en_pixel  out  1  VIC pixel enable

Behaviour:
- Cycle indices: EXT0-3=0-3, CPU0-3=4-7, COP0-3=8-11, VID0-3=12-15, NOP0-1=16-17. END = model ? END_B : END_P.
- Internal pre counter increments every clock. If pre >= END (this covers a model switch while pre is 16 or 17), next pre=0, phase toggles, and rfsh_cnt increments, wrapping at 2^RFSH_BITS.
- At a wrap with rfsh_cnt==0 (pre-increment value): sys_enable <= ~pause and refresh=1 for exactly the next clock. Pause/resume therefore takes effect only on refresh frames.
- cycle = sys_enable ? pre : 0.
- phase forced to 0 while reset or !sys_enable.
- Speed gating: g = phase | sys2 | ~sys_enable term excluded, where sys2 = model | (turbo & ~slow_io).
- Slot flags:
  - ext_cycle = cycle in 0..3 && (!phase || rfsh_cnt!=0)
  - cpu_cycle = cycle in 4..7 && g
  - cop_cycle = cycle in 8..11 && g
  - vid_cycle = cycle in 12..15
- Enables:
  - en_io_n = cycle==6 && g
  - en_cpu = cycle==7 && g
  - en_io_p = cycle==8 && g
  - en_cop = cycle==11 && copro_en
  - en_vid = cycle==15
- RAM: ram_ce = cs_ram && ((cycle==4 && g) || (cycle==8 && copro_en) || cycle==12). ram_we = cpu_we && cpu_cycle. Both are combinational from the registered cycle, so they are valid in the same clock.
- Pixel: 2-bit counter increments each clock and clears on reset, !sys_enable, or cycle==END. en_pixel = (cnt==3) & ~model.
- Reset values: pre=0, phase=0, rfsh_cnt=0, sys_enable=0, refresh=0, pixel cnt=0. Hence cycle=0, pause_out=1, and all enables are 0 except ext_cycle=1.
- After reset deassert, the first refresh and enable occur at the first wrap (END+1 clocks later).
- Reset mid-frame: all state is cleared on the next edge with no residual strobes.
- Simultaneous wrap and reset: reset wins.
- Pause asserted between refresh frames: ignored until the next rfsh_cnt==0 wrap.
- During pause, pre keeps running and refresh is still issued every 2^RFSH_BITS frames, so SDRAM stays refreshed.

Decomposition:
- cbm2_pkg holds sys_cycle_t enum (CYCLE_EXT0..CYCLE_NOP1) and the slot-boundary constants; cbm2_main is later refactored to import it.
- No sub-module needed; the pixel counter stays inline.

Test Plan:
- Reset, model=0, pause=0 -> refresh pulse 16 clocks after reset release; sys_enable=1 from then; phase toggles every 16 clocks; refresh repeats every 128 clocks.
- model=1 -> frame period 18 clocks; en_pixel never 1; cpu_cycle asserted in cycles 4-7 of both phases.
- model=0, turbo=0 -> en_cpu only when phase=1 (once per 32 clocks). With turbo=1, slow_io=0 -> every 16 clocks. With slow_io=1 -> back to phase=1 only.
- cs_ram=1, cpu_we=1, copro_en=1, model=1 -> ram_ce at cycles 4, 8, 12; ram_we high only at cycles 4-7.
- pause=1 mid-frame -> sys_enable drops only at the next rfsh_cnt==0 wrap; cycle then holds 0, refresh continues every 144 clocks; pause=0 -> re-enable at the following refresh wrap.
- model switched 1->0 while pre=17 -> wrap on next clock, phase toggles once, no cycle value >15 output thereafter.
